// File: rtl/controlador_acesso_4faixas.sv
// Bus access controller: one-hot select in, per-region wait states, ack/err out.
// Optional macro CS_CHECK_EN: when defined, multi-bit selects go to ERROR.
// Ports: clk, rst_n, req, we, addr, wdata, cs, mem_rdata in;
//        mem_cs, mem_we, mem_addr, mem_wdata, rdata, ack, err, busy out.
module controlador_acesso_4faixas #(
  parameter logic [3:0] WAIT0 = 4'd0,
  parameter logic [3:0] WAIT1 = 4'd1,
  parameter logic [3:0] WAIT2 = 4'd2,
  parameter logic [3:0] WAIT3 = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [3:0]  cs,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_cs,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERROR
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [3:0]  mem_cs_q;
  logic        mem_we_q;
  logic [9:0]  mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic [7:0]  rdata_q;
  logic        ack_q;
  logic        err_q;
  logic        busy_q;

  logic [3:0]  sel_d;
  logic        valid_d;
  logic [3:0]  wait_d;
  logic [7:0]  lane_d;

  // Upper address bits only matter to the decoder upstream.
  logic        unused_addr;
  assign unused_addr = ^addr[15:10];

  always_comb begin
    // Isolate the lowest set bit of the select.
    sel_d = cs & (~cs + 4'd1);
`ifdef CS_CHECK_EN
    valid_d = (cs != 4'd0) &&
              ((cs & (cs - 4'd1)) == 4'd0);
`else
    valid_d = (cs != 4'd0);
`endif
    wait_d = 4'd0;
    unique case (1'b1)
      sel_d[0]: wait_d = WAIT0;
      sel_d[1]: wait_d = WAIT1;
      sel_d[2]: wait_d = WAIT2;
      sel_d[3]: wait_d = WAIT3;
      default:  wait_d = 4'd0;
    endcase
  end

  always_comb begin
    lane_d = 8'h00;
    unique case (1'b1)
      sel_q[0]: lane_d = mem_rdata[7:0];
      sel_q[1]: lane_d = mem_rdata[15:8];
      sel_q[2]: lane_d = mem_rdata[23:16];
      sel_q[3]: lane_d = mem_rdata[31:24];
      default:  lane_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sel_q       <= 4'd0;
      we_q        <= 1'b0;
      mem_cs_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 10'd0;
      mem_wdata_q <= 8'd0;
      rdata_q     <= 8'd0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            sel_q  <= sel_d;
            we_q   <= we;
            busy_q <= 1'b1;
            if (valid_d) begin
              state_q     <= ACCESS;
              cnt_q       <= wait_d;
              mem_cs_q    <= sel_d;
              mem_we_q    <= we;
              mem_addr_q  <= addr[9:0];
              mem_wdata_q <= wdata;
            end else begin
              state_q <= ERROR;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q  <= DONE;
            mem_cs_q <= 4'd0;
            mem_we_q <= 1'b0;
            ack_q    <= 1'b1;
            if (!we_q) rdata_q <= lane_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // Registered ack/err are raised on exit so they appear
        // one cycle after the sampling edge.
        ERROR: begin
          state_q <= DONE;
          ack_q   <= 1'b1;
          err_q   <= 1'b1;
          rdata_q <= 8'hFF;
        end
        DONE: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_controlador_acesso_4faixas.sv
// Directed bench for controlador_acesso_4faixas.
// Vector table plus reset-abort and back-to-back sequences.
module tb_controlador_acesso_4faixas;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [3:0]  cs;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_cs;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  rdata;
  logic        ack;
  logic        err;
  logic        busy;

  controlador_acesso_4faixas dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .cs        (cs),
    .mem_rdata (mem_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  cs;
    logic [31:0] mrd;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_cs;
    int          exp_cyc;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t v [10];
  int   checks;
  int   failures;
  int   cur;

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL t%0d %s got=%0h exp=%0h",
               cur, n, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int ack_c;
    int cyc;
    int bad;
    ack_c = 0;
    cyc = 0;
    bad = 0;
    we = t.we;
    addr = t.addr;
    wdata = t.wdata;
    cs = t.cs;
    mem_rdata = t.mrd;
    req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (mem_cs != 4'd0) begin
        cyc++;
        if (mem_cs !== t.exp_cs ||
            mem_we !== t.we ||
            mem_addr !== t.addr[9:0] ||
            mem_wdata !== t.wdata ||
            ack !== 1'b0)
          bad++;
      end
      if (ack) begin
        ack_c = c;
        req = 1'b0;
        break;
      end
    end
    chk("ack_lat", 64'(ack_c), 64'(t.exp_lat));
    chk("err", 64'(err), 64'(t.exp_err));
    chk("rdata", 64'(rdata), 64'(t.exp_rdata));
    chk("cs_cycles", 64'(cyc), 64'(t.exp_cyc));
    chk("mem_fields", 64'(bad), 64'd0);
    chk("ack_cycle", 64'({busy, mem_cs, mem_we}),
        64'({1'b1, 4'd0, 1'b0}));
    @(posedge clk);
    #1;
    chk("after_ack", 64'({ack, err, busy}), 64'd0);
  endtask

  initial begin
    int n_ack;
    int a1;
    int a2;
    int idle;
    logic [7:0] r1;
    logic [7:0] r2;

    checks = 0;
    failures = 0;
    cur = 0;

    v[0] = '{1'b0, 16'h0400, 8'h00, 4'b0001,
             32'hDDCCBBA5, 1'b0, 2, 4'b0001, 1, 8'hA5};
    v[1] = '{1'b1, 16'h7C10, 8'h3C, 4'b1000,
             32'hDDCCBBA5, 1'b0, 5, 4'b1000, 4, 8'hA5};
    v[2] = '{1'b0, 16'h0805, 8'h00, 4'b0010,
             32'h11223344, 1'b0, 3, 4'b0010, 2, 8'h33};
    v[3] = '{1'b0, 16'h0C00, 8'h00, 4'b0100,
             32'h11223344, 1'b0, 4, 4'b0100, 3, 8'h22};
    v[4] = '{1'b0, 16'h7FFF, 8'h00, 4'b1000,
             32'h11223344, 1'b0, 5, 4'b1000, 4, 8'h11};
    v[5] = '{1'b0, 16'h2000, 8'h00, 4'b0000,
             32'h11223344, 1'b1, 2, 4'b0000, 0, 8'hFF};
    v[6] = '{1'b1, 16'h0BFF, 8'h5A, 4'b0010,
             32'h11223344, 1'b0, 3, 4'b0010, 2, 8'hFF};
`ifdef CS_CHECK_EN
    v[7] = '{1'b0, 16'h0401, 8'h00, 4'b0011,
             32'h11223344, 1'b1, 2, 4'b0000, 0, 8'hFF};
    v[8] = '{1'b1, 16'h3000, 8'h77, 4'b0000,
             32'h11223344, 1'b1, 2, 4'b0000, 0, 8'hFF};
    v[9] = '{1'b0, 16'h0C12, 8'h00, 4'b1100,
             32'h11223344, 1'b1, 2, 4'b0000, 0, 8'hFF};
`else
    v[7] = '{1'b0, 16'h0401, 8'h00, 4'b0011,
             32'h11223344, 1'b0, 2, 4'b0001, 1, 8'h44};
    v[8] = '{1'b1, 16'h3000, 8'h77, 4'b0000,
             32'h11223344, 1'b1, 2, 4'b0000, 0, 8'hFF};
    v[9] = '{1'b0, 16'h0C12, 8'h00, 4'b1100,
             32'h11223344, 1'b0, 4, 4'b0100, 3, 8'h22};
`endif

    rst_n = 1'b0;
    req = 1'b0;
    we = 1'b0;
    addr = 16'h0;
    wdata = 8'h0;
    cs = 4'h0;
    mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        64'({mem_cs, mem_we, mem_addr, mem_wdata,
             rdata, ack, err, busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      cur = i;
      run_vec(v[i]);
    end

    // Reset during the 2nd ACCESS cycle of a region-3 write.
    cur = 10;
    we = 1'b1;
    addr = 16'h7C10;
    wdata = 8'h3C;
    cs = 4'b1000;
    req = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_abort", 64'({mem_cs, mem_we, busy}),
        64'({4'b1000, 1'b1, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("abort_now",
        64'({mem_cs, mem_we, busy, mem_addr, rdata}), 64'd0);
    req = 1'b0;
    #2;
    rst_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (ack || busy) n_ack++;
    end
    chk("no_ack_after_abort", 64'(n_ack), 64'd0);

    // Back-to-back reads, region 1 then region 2, req held high.
    cur = 11;
    n_ack = 0;
    a1 = 0;
    a2 = 0;
    idle = 0;
    r1 = 8'h00;
    r2 = 8'h00;
    we = 1'b0;
    addr = 16'h0800;
    cs = 4'b0010;
    mem_rdata = 32'h11223344;
    req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (n_ack == 1 && !busy) idle++;
      if (ack) begin
        n_ack++;
        if (n_ack == 1) begin
          a1 = c;
          r1 = rdata;
          addr = 16'h0C00;
          cs = 4'b0100;
        end else begin
          a2 = c;
          r2 = rdata;
          req = 1'b0;
          break;
        end
      end
    end
    chk("b2b_ack1", 64'(a1), 64'd3);
    chk("b2b_ack2", 64'(a2), 64'd8);
    chk("b2b_idle", 64'(idle), 64'd1);
    chk("b2b_rdata1", 64'(r1), 64'h33);
    chk("b2b_rdata2", 64'(r2), 64'h22);
    @(posedge clk);
    #1;
    chk("b2b_end", 64'({ack, busy}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
